// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  // Real-world timing at the production clock: one floor of travel and one door dwell.
  localparam int DEF_TRAVEL_CYCLES = 250_000_000;
  localparam int DEF_DOOR_CYCLES   = 100_000_000;

  // Widest building the controller supports; masks are computed at this width.
  localparam int MAX_FLOORS = 16;

  // Mask of floors strictly beyond 'cur' in the given direction, limited to
  // the floors that exist. AND with the pending calls to get "ahead" (up = dir_up)
  // or "behind" (up = ~dir_up).
  function automatic logic [MAX_FLOORS-1:0] beyond_mask(
    input logic [3:0] cur,
    input logic       up,
    input int         num_floors
  );
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < num_floors) begin
        if (up) m[i] = (i > int'(cur));
        else    m[i] = (i < int'(cur));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Up-counter with synchronous clear, enable and terminal-count pulse.
// The counter wraps to zero on its own at the terminal count, so a caller
// that stays in the same state gets a periodic pulse every limit_i+1 cycles.
module elev_tick_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tc must not depend on clr_i: the caller derives clr_i from a state decision that uses tc.
  assign tc_o = en_i && (cnt_q == limit_i);

  // Next count: clear wins, otherwise advance and wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: latches floor calls, travels in one
// direction while calls remain ahead, opens the door at each called floor,
// and reverses only when nothing is left ahead.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | cab parked, door closed, waiting for a call
//   MOVE    | travelling; floor steps once per TRAVEL_CYCLES
//   DOOR    | door open at a serviced floor for DOOR_CYCLES (call re-holds)
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int  NUM_FLOORS    = 8,
  parameter int  TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int  DOOR_CYCLES   = DEF_DOOR_CYCLES,
  localparam int FLOOR_W       = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    floor,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [FLOOR_W-1:0]      step_floor;
  logic [NUM_FLOORS-1:0]   onehot_q, onehot_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [NUM_FLOORS-1:0]   svc_mask;
  logic                    dir_q, dir_d;
  logic                    moving_q, door_q;

  logic [MAX_FLOORS-1:0]   pend_ext;
  logic [MAX_FLOORS-1:0]   fwd_mask, rev_mask;
  logic                    ahead, behind;
  logic                    door_hold;
  logic                    tmr_en, tmr_clr, tmr_tc;
  logic [CNT_W-1:0]        tmr_limit;

  // Direction bookkeeping is done at the package width so one helper serves any building size.
  assign pend_ext = MAX_FLOORS'(pending_q);
  assign fwd_mask = beyond_mask(4'(floor_q), dir_q, NUM_FLOORS);
  assign rev_mask = beyond_mask(4'(floor_q), ~dir_q, NUM_FLOORS);
  assign ahead    = |(pend_ext & fwd_mask);
  assign behind   = |(pend_ext & rev_mask);

  // MOVE is only entered with a call ahead, so this never steps past either end.
  assign step_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  // Pressing the current floor's button while the door is open keeps it open.
  assign door_hold = (state_q == ST_DOOR) && call_req[floor_q];

  // One timer serves both MOVE and DOOR; its limit follows the state.
  assign tmr_en    = (state_q != ST_IDLE);
  assign tmr_limit = (state_q == ST_MOVE) ? CNT_W'(TRAVEL_CYCLES - 1)
                                          : CNT_W'(DOOR_CYCLES - 1);
  assign tmr_clr   = (state_d != state_q) || door_hold;

  elev_tick_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  // Next-state, direction, floor and service decisions.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    svc_mask = '0;

    case (state_q)
      ST_IDLE: begin
        // A call at the parked floor is serviced on the spot and never shows as pending.
        if (pending_q[floor_q] || call_req[floor_q]) begin
          state_d  = ST_DOOR;
          svc_mask = NUM_FLOORS'(1) << floor_q;
        end else if (ahead) begin
          state_d = ST_MOVE;
        end else if (behind) begin
          dir_d   = ~dir_q;
          state_d = ST_MOVE;
        end
      end

      ST_MOVE: begin
        if (tmr_tc) begin
          floor_d = step_floor;
          // A button pressed on the very cycle of arrival counts as serviced.
          if (pending_q[step_floor] || call_req[step_floor]) begin
            state_d  = ST_DOOR;
            svc_mask = NUM_FLOORS'(1) << step_floor;
          end
        end
      end

      ST_DOOR: begin
        svc_mask = NUM_FLOORS'(1) << floor_q;
        if (tmr_tc && !door_hold) begin
          if (ahead) begin
            state_d = ST_MOVE;
          end else if (behind) begin
            dir_d   = ~dir_q;
            state_d = ST_MOVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Calls latch until serviced; service is the only way a bit clears.
  always_comb begin
    pending_d = (pending_q | call_req) & ~svc_mask;
    onehot_d  = NUM_FLOORS'(1) << floor_d;
  end

  // Controller registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      floor_q   <= '0;
      onehot_q  <= NUM_FLOORS'(1);
      dir_q     <= 1'b1;
      pending_q <= '0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      onehot_q  <= onehot_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      moving_q  <= (state_d == ST_MOVE);
      door_q    <= (state_d == ST_DOOR);
    end
  end

  assign floor        = floor_q;
  assign floor_onehot = onehot_q;
  assign dir_up       = dir_q;
  assign moving       = moving_q;
  assign door_open    = door_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with a cycle-level reference model.
module tb_elevator_scan_ctrl;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 3;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] call_req;
  logic [2:0]    floor;
  logic [NF-1:0] floor_onehot;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state: mode, floor, direction, calls, cycles left in the current period.
  int      m_floor = 0;
  bit      m_up    = 1'b1;
  bit [7:0] m_pend = 8'h00;
  int      m_mode  = M_IDLE;
  int      m_left  = 0;

  elevator_scan_ctrl #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .call_req     (call_req),
    .floor        (floor),
    .floor_onehot (floor_onehot),
    .dir_up       (dir_up),
    .moving       (moving),
    .door_open    (door_open),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  function automatic bit req_beyond(input bit [7:0] p, input int f, input bit up);
    for (int j = 0; j < NF; j++) begin
      if (p[j] && (up ? (j > f) : (j < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: applies the controller rules at each rising edge.
  always @(posedge clk) begin
    bit [7:0] c;
    bit [7:0] old;
    int nf;
    c   = call_req;
    old = m_pend;
    if (!rst_n) begin
      m_floor = 0; m_up = 1'b1; m_pend = 8'h00; m_mode = M_IDLE; m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (old[m_floor] || c[m_floor]) begin
            m_mode = M_DOOR; m_left = DC; c[m_floor] = 1'b0; m_pend[m_floor] = 1'b0;
          end else if (req_beyond(old, m_floor, m_up)) begin
            m_mode = M_MOVE; m_left = TC;
          end else if (req_beyond(old, m_floor, !m_up)) begin
            m_up = !m_up; m_mode = M_MOVE; m_left = TC;
          end
        end
        M_MOVE: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            nf = m_up ? m_floor + 1 : m_floor - 1;
            m_floor = nf;
            if (old[nf] || c[nf]) begin
              m_mode = M_DOOR; m_left = DC; c[nf] = 1'b0; m_pend[nf] = 1'b0;
            end else begin
              m_left = TC;
            end
          end
        end
        default: begin
          if (c[m_floor]) begin
            c[m_floor] = 1'b0; m_left = DC;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              if (req_beyond(old, m_floor, m_up)) begin
                m_mode = M_MOVE; m_left = TC;
              end else if (req_beyond(old, m_floor, !m_up)) begin
                m_up = !m_up; m_mode = M_MOVE; m_left = TC;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end
        end
      endcase
      m_pend = m_pend | c;
    end
  end

  // Per-cycle comparison of every output against the model, on the falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_oh;
    if (chk_en) begin
      exp_oh = 8'd1 << m_floor;
      total++;
      if (floor !== 3'(m_floor) || floor_onehot !== exp_oh || dir_up !== m_up ||
          moving !== (m_mode == M_MOVE) || door_open !== (m_mode == M_DOOR) ||
          pending !== m_pend) begin
        bad++;
        $display("FAIL model t=%0t got/want floor=%0d/%0d oh=%h/%h dir=%0b/%0b mov=%0b/%0b door=%0b/%0b pend=%h/%h",
                 $time, floor, m_floor, floor_onehot, exp_oh, dir_up, m_up,
                 moving, (m_mode == M_MOVE), door_open, (m_mode == M_DOOR), pending, m_pend);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic call_pulse(input logic [NF-1:0] v);
    call_req = v;
    tick();
    call_req = '0;
  endtask

  task automatic wait_door(input string name, output int f);
    int n = 0;
    while (!door_open && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_door_seen"}, int'(door_open), 1);
    f = int'(floor);
  endtask

  task automatic wait_close(input string name);
    int n = 0;
    while (door_open && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_door_closed"}, int'(door_open), 0);
  endtask

  task automatic wait_moving_at(input string name, input int f);
    int n = 0;
    while (!(moving && int'(floor) == f) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_at_floor"}, int'(moving && int'(floor) == f), 1);
  endtask

  initial begin
    int n;
    int d;
    int f;

    rst_n    = 1'b0;
    call_req = '0;
    tick();
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset values.
    chk("rst_floor", int'(floor), 0);
    chk("rst_onehot", int'(floor_onehot), 1);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_moving", int'(moving), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_pending", int'(pending), 0);

    // Call at the parked floor opens the door next cycle without latching.
    call_pulse(8'h01);
    chk("here_door", int'(door_open), 1);
    chk("here_pending", int'(pending), 0);
    d = 0;
    while (door_open && d < 50) begin
      d++;
      tick();
    end
    chk("here_door_cycles", d, DC);

    // Single call to floor 5: 5 floors x 4 cycles of travel, 3 cycles of door.
    call_pulse(8'h20);
    chk("c5_pending", int'(pending), 32'h20);
    chk("c5_still_idle", int'(moving), 0);
    tick();
    n = 0;
    while (moving && n < 100) begin
      n++;
      tick();
    end
    chk("c5_move_cycles", n, 20);
    chk("c5_floor", int'(floor), 5);
    chk("c5_onehot", int'(floor_onehot), 32'h20);
    chk("c5_pending_clear", int'(pending), 0);
    d = 0;
    while (door_open && d < 50) begin
      d++;
      tick();
    end
    chk("c5_door_cycles", d, DC);
    chk("c5_idle_moving", int'(moving), 0);

    // Reverse to floor 2, then hold its button for 5 door cycles: 5+3 open cycles.
    call_pulse(8'h04);
    wait_door("hold", f);
    chk("hold_floor", f, 2);
    chk("hold_dir", int'(dir_up), 0);
    d = 0;
    while (door_open && d < 50) begin
      d++;
      call_req = (d <= 5) ? 8'h04 : 8'h00;
      tick();
    end
    call_req = '0;
    chk("hold_door_cycles", d, 8);

    // At floor 3 going up with {6} pending, a call to 1 waits for the sweep to finish.
    call_pulse(8'h40);
    wait_moving_at("scan", 3);
    chk("scan_pend_before", int'(pending), 32'h40);
    chk("scan_dir_up", int'(dir_up), 1);
    call_pulse(8'h02);
    chk("scan_pend_after", int'(pending), 32'h42);
    wait_door("scan_a", f);
    chk("scan_first", f, 6);
    chk("scan_first_dir", int'(dir_up), 1);
    wait_close("scan_a");
    wait_door("scan_b", f);
    chk("scan_second", f, 1);
    chk("scan_second_dir", int'(dir_up), 0);
    wait_close("scan_b");

    // Park at 4 heading up, then calls {0,7} together: 7 first, then 0.
    call_pulse(8'h10);
    wait_door("park4", f);
    chk("park4_floor", f, 4);
    wait_close("park4");
    chk("park4_dir", int'(dir_up), 1);
    call_pulse(8'h81);
    chk("ends_pending", int'(pending), 32'h81);
    wait_door("ends_a", f);
    chk("ends_first", f, 7);
    wait_close("ends_a");
    wait_door("ends_b", f);
    chk("ends_second", f, 0);
    chk("ends_second_dir", int'(dir_up), 0);
    wait_close("ends_b");

    // Button for floor 3 pressed only on the arrival cycle: serviced, never pending.
    call_pulse(8'h20);
    wait_moving_at("arr", 2);
    tick();
    tick();
    tick();
    call_pulse(8'h08);
    chk("arr_door", int'(door_open), 1);
    chk("arr_floor", int'(floor), 3);
    chk("arr_pending", int'(pending), 32'h20);
    wait_close("arr_a");
    wait_door("arr_b", f);
    chk("arr_next", f, 5);
    wait_close("arr_b");

    // Reset mid-travel abandons everything and reads floor 0.
    call_pulse(8'h01);
    wait_door("back0", f);
    wait_close("back0");
    call_pulse(8'h40);
    wait_moving_at("mrst", 3);
    chk("mrst_pend_before", int'(pending), 32'h40);
    rst_n = 1'b0;
    tick();
    chk("mrst_floor", int'(floor), 0);
    chk("mrst_pending", int'(pending), 0);
    chk("mrst_moving", int'(moving), 0);
    chk("mrst_door", int'(door_open), 0);
    chk("mrst_dir", int'(dir_up), 1);
    chk("mrst_onehot", int'(floor_onehot), 1);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mrst_stays_idle", int'(moving), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 8: number of floors, numbered 0..NUM_FLOORS-1, legal range 2..16.
REQ-002 Parameter TRAVEL_CYCLES, default 250_000_000: clk cycles to move one floor, minimum 2.
REQ-003 Parameter DOOR_CYCLES, default 100_000_000: clk cycles the door stays open, minimum 2.
REQ-004 Derived constant FLOOR_W = clog2(NUM_FLOORS), minimum 1.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 call_req  in  NUM_FLOORS  level call buttons, bit i = request floor i, sampled every clk.
REQ-008 floor  out  FLOOR_W  current cab floor.
REQ-009 floor_onehot  out  NUM_FLOORS  one-hot of floor, registered in the same cycle as floor.
REQ-010 dir_up  out  1  travel direction, 1 = up.
REQ-011 moving  out  1  high in MOVE.
REQ-012 door_open  out  1  high in DOOR.
REQ-013 pending  out  NUM_FLOORS  latched, not yet serviced calls.

Function
REQ-014 States IDLE, MOVE, DOOR; all outputs registered.
REQ-015 Latch: pending[i] sets 1 cycle after call_req[i]=1, except when i==floor and the state is DOOR or the cab is arriving at i that cycle (call counts as serviced).
REQ-016 pending[i] clears only on service at floor i; no other clear path.
REQ-017 "ahead" = any pending bit strictly beyond floor in dir_up direction; "behind" = strictly opposite.
REQ-018 IDLE: pending[floor]=1 -> DOOR next cycle, clear bit; else ahead -> MOVE, dir unchanged; else behind -> invert dir_up, MOVE; else stay IDLE.
REQ-019 MOVE: cycle counter runs 0..TRAVEL_CYCLES-1; at terminal count floor steps +/-1 per dir_up and counter returns to 0.
REQ-020 Arrival: if pending[new floor] or call_req[new floor] -> DOOR next cycle, clear bit; else remain MOVE.
REQ-021 floor never exceeds NUM_FLOORS-1 nor goes below 0; MOVE is entered only with a request ahead, so no wrap-around occurs.
REQ-022 DOOR: counter runs 0..DOOR_CYCLES-1; call_req[floor]=1 in DOOR restarts the counter at 0 (door-hold).
REQ-023 DOOR expiry: ahead -> MOVE, dir kept; else behind -> invert dir_up, MOVE; else IDLE.
REQ-024 Direction never reverses while requests remain ahead (SCAN order).
REQ-025 Counter width = clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)); counter zeroed on every state change.

Reset
REQ-026 rst_n=0 at a clk edge: state IDLE, floor 0, floor_onehot 1, dir_up 1, moving 0, door_open 0, pending 0, counter 0.
REQ-027 Reset mid-MOVE or mid-DOOR abandons all pending calls; there is no position recovery, so the cab reads floor 0.

Structure
REQ-028 Package elevator_pkg holds the state enum, the default TRAVEL_CYCLES/DOOR_CYCLES, and a function computing ahead/behind masks.
REQ-029 One sub-module, elev_tick_timer: a parameterised counter with clear, enable and terminal-count pulse, shared by the MOVE and DOOR states.
REQ-030 The existing hex_controller display connects externally to floor; it is not instantiated here.

Verification (NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-031 Reset, call_req[5] pulse 1 cycle -> pending=0x20, MOVE up, floor reaches 5 after 20 MOVE cycles, door_open 3 cycles, pending 0, then IDLE.
REQ-032 At floor 3 moving up with pending {6}, call floor 1 -> cab services 6 first, then reverses, services 1; dir_up=0 at 1.
REQ-033 IDLE at floor 0, call_req[0]=1 -> DOOR next cycle, pending stays 0.
REQ-034 In DOOR at floor 2, hold call_req[2] for 5 cycles -> door_open stays high 5+3 cycles.
REQ-035 Simultaneous calls {0,7} from floor 4 IDLE, dir_up=1 -> services 7 then 0; floor never leaves 0..7.
REQ-036 rst_n low mid-MOVE (floor 3, pending {6}) -> next cycle floor 0, pending 0, IDLE.
